// File: rtl/ysyx_22041207_arb_pkg.sv
// ============================================================================
// Module      : ysyx_22041207_arb_pkg
// Description : Shared types and widths for the IF/LSU memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_22041207_arb_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int INST_W = 32;
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  // Instructions are 32-bit; addr[2] selects the half of the 64-bit beat.
  function automatic logic [INST_W-1:0] pick_inst(input logic sel_hi,
                                                  input logic [DATA_W-1:0] beat);
    return sel_hi ? beat[DATA_W-1:INST_W] : beat[INST_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22041207_arb_stats.sv
// ============================================================================
// Module      : ysyx_22041207_arb_stats
// Description : Grant and IF-stall event counters for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22041207_arb_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_grant,
  input  logic        lsu_grant,
  input  logic        if_stall,
  input  logic [63:0] if_addr,
  output logic [31:0] stat_if_grants,
  output logic [31:0] stat_lsu_grants,
  output logic [31:0] stat_if_stall_cycles
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_grants       <= '0;
      stat_lsu_grants      <= '0;
      stat_if_stall_cycles <= '0;
    end else begin
      if (if_grant)  stat_if_grants       <= stat_if_grants + 32'd1;
      if (lsu_grant) stat_lsu_grants      <= stat_lsu_grants + 32'd1;
      if (if_stall)  stat_if_stall_cycles <= stat_if_stall_cycles + 32'd1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && if_grant) $display("arb if %x", if_addr);
  end
`endif

endmodule

`default_nettype wire

// File: rtl/ysyx_22041207_mem_arb.sv
// ============================================================================
// Module      : ysyx_22041207_mem_arb
// Description : Single-outstanding memory-port arbiter between IF and LSU,
//               LSU-priority with IF starvation guard and flush-drop.
//               Optional counters: define YSYX_22041207_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22041207_mem_arb
  import ysyx_22041207_arb_pkg::*;
#(
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  input  logic              if_flush,
  output logic              if_resp_valid,
  output logic [INST_W-1:0] if_resp_inst,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
`ifdef YSYX_22041207_ARB_STATS_EN
  output logic [31:0]       stat_if_grants,
  output logic [31:0]       stat_lsu_grants,
  output logic [31:0]       stat_if_stall_cycles,
`endif
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  localparam logic [3:0] c_max_streak = 4'(MAX_LSU_STREAK);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  arb_owner_e        r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic [DATA_W-1:0] r_rdata;
  logic              r_drop;
  logic [3:0]        r_streak;
  logic              w_pick_if;
  logic              w_if_grant;
  logic              w_lsu_grant;
  logic              w_in_flight;

  // Winner is chosen before the flush mask, so a flushed IF winner grants nobody.
  always_comb begin
    w_pick_if     = if_req_valid && (!lsu_req_valid || (r_streak == c_max_streak));
    if_req_ready  = rst_n && (r_state == IDLE) && w_pick_if && !if_flush;
    lsu_req_ready = rst_n && (r_state == IDLE) && lsu_req_valid && !w_pick_if;
  end

  assign w_if_grant  = if_req_valid && if_req_ready;
  assign w_lsu_grant = lsu_req_valid && lsu_req_ready;
  assign w_in_flight = (r_state == ISSUE) || (r_state == WAIT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_if_grant || w_lsu_grant) w_state_next = ISSUE;
      ISSUE:   if (mem_req_ready) w_state_next = WAIT;
      WAIT:    if (mem_resp_valid) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= OWN_IF;
      r_addr   <= '0;
      r_wen    <= 1'b0;
      r_wdata  <= '0;
      r_wmask  <= '0;
      r_rdata  <= '0;
      r_drop   <= 1'b0;
      r_streak <= '0;
    end else begin
      if (w_if_grant) begin
        r_owner  <= OWN_IF;
        r_addr   <= if_req_addr;
        r_wen    <= 1'b0;
        r_wdata  <= '0;
        r_wmask  <= '0;
        r_streak <= '0;
      end else if (w_lsu_grant) begin
        r_owner <= OWN_LSU;
        r_addr  <= lsu_req_addr;
        r_wen   <= lsu_req_wen;
        r_wdata <= lsu_req_wdata;
        r_wmask <= lsu_req_wmask;
        if (if_req_valid && (r_streak < c_max_streak)) r_streak <= r_streak + 4'd1;
      end
      if ((r_state == WAIT) && mem_resp_valid) r_rdata <= mem_resp_rdata;
      if (r_state == RESP)
        r_drop <= 1'b0;
      else if (w_in_flight && (r_owner == OWN_IF) && if_flush)
        r_drop <= 1'b1;
    end
  end

  assign mem_req_valid  = (r_state == ISSUE);
  assign mem_req_addr   = (r_owner == OWN_IF) ? {r_addr[ADDR_W-1:3], 3'b000} : r_addr;
  assign mem_req_wen    = r_wen;
  assign mem_req_wdata  = r_wdata;
  assign mem_req_wmask  = r_wmask;

  assign if_resp_valid  = (r_state == RESP) && (r_owner == OWN_IF) && !r_drop;
  assign if_resp_inst   = pick_inst(r_addr[2], r_rdata);
  assign lsu_resp_valid = (r_state == RESP) && (r_owner == OWN_LSU);
  assign lsu_resp_rdata = r_rdata;

`ifdef YSYX_22041207_ARB_STATS_EN
  ysyx_22041207_arb_stats u_stats (
    .clk                  (clk),
    .rst_n                (rst_n),
    .if_grant             (w_if_grant),
    .lsu_grant            (w_lsu_grant),
    .if_stall             (if_req_valid && !if_req_ready),
    .if_addr              (if_req_addr),
    .stat_if_grants       (stat_if_grants),
    .stat_lsu_grants      (stat_lsu_grants),
    .stat_if_stall_cycles (stat_if_stall_cycles)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041207_mem_arb.sv
// ============================================================================
// Module      : tb_ysyx_22041207_mem_arb
// Description : Self-checking bench for the IF/LSU memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ysyx_22041207_mem_arb;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_flush, if_resp_valid;
  logic [63:0] if_req_addr;
  logic [31:0] if_resp_inst;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
  logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
  logic [7:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [7:0]  mem_req_wmask;
`ifdef YSYX_22041207_ARB_STATS_EN
  logic [31:0] s_if, s_lsu, s_stall;
`endif

  ysyx_22041207_mem_arb #(.MAX_LSU_STREAK(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid),
`ifdef YSYX_22041207_ARB_STATS_EN
    .stat_if_grants(s_if), .stat_lsu_grants(s_lsu), .stat_if_stall_cycles(s_stall),
`endif
    .mem_resp_rdata(mem_resp_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  // Memory contents are a fixed function of the beat address.
  function automatic logic [63:0] rd(input logic [63:0] a);
    return {a[31:0] ^ 32'h1357_9bdf, a[31:0] + 32'h0f0f_0f0f};
  endfunction

  // Requester intent
  bit          if_pend, lsu_pend, auto_if, auto_lsu;
  logic [63:0] if_addr_q, lsu_addr_q, lsu_wdata_q;
  logic        lsu_wen_q;
  logic [7:0]  lsu_wmask_q;

  // Memory behaviour
  bit          mm_pending, mm_ready_rand, stray_en, ovr_en;
  int          mm_delay, mm_dly_fixed, mm_stall;
  logic [63:0] mm_addr, ovr_data;

  // Transaction-level reference model
  bit          m_busy, m_issued, m_resp_now, m_own_if, m_drop;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic        m_wen;
  logic [7:0]  m_wmask;
  int          m_streak;

  // Observations
  string       grant_log;
  int          cyc, last_grant_cyc, last_ifresp_cyc, issue_cycles, if_resp_cnt, lsu_resp_cnt;
  logic [63:0] last_mem_addr, last_lsu_rdata;
  logic [31:0] last_inst;

  task automatic cycle(input bit rnd);
    bit pick_if, e_if_rdy, e_lsu_rdy, e_mvalid, e_ifr, e_lr;
    logic [63:0] e_addr;
    if (!rst_n) begin
      m_busy = 0; m_issued = 0; m_resp_now = 0; m_drop = 0; m_streak = 0;
    end
    if (rnd) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr_q = 64'h8000_0000 + 64'($urandom_range(0, 1023) * 4);
      end
      if (!lsu_pend && $urandom_range(0, 2) == 0) begin
        lsu_pend = 1; lsu_addr_q = 64'h8000_1000 + 64'($urandom_range(0, 4095));
        lsu_wen_q = 1'($urandom_range(0, 1)); lsu_wdata_q = {$urandom, $urandom};
        lsu_wmask_q = 8'($urandom_range(0, 255));
      end
      if_flush = ($urandom_range(0, 9) == 0);
    end
    if_req_valid = if_pend; if_req_addr = if_addr_q;
    lsu_req_valid = lsu_pend; lsu_req_addr = lsu_addr_q; lsu_req_wen = lsu_wen_q;
    lsu_req_wdata = lsu_wdata_q; lsu_req_wmask = lsu_wmask_q;

    mem_resp_valid = 0; mem_resp_rdata = {$urandom, $urandom};
    if (mm_pending) begin
      if (mm_delay == 0) begin
        mem_resp_valid = 1; mem_resp_rdata = ovr_en ? ovr_data : rd(mm_addr); mm_pending = 0;
      end else mm_delay--;
    end else if (stray_en && !(m_busy && m_issued && !m_resp_now) && $urandom_range(0, 7) == 0)
      mem_resp_valid = 1;
    if (m_busy && !m_issued && mm_stall > 0) begin
      mem_req_ready = 0; mm_stall--;
    end else mem_req_ready = mm_ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;

    @(negedge clk);
    pick_if   = if_req_valid && (!lsu_req_valid || m_streak == MAX);
    e_if_rdy  = rst_n && !m_busy && pick_if && !if_flush;
    e_lsu_rdy = rst_n && !m_busy && lsu_req_valid && !pick_if;
    chk("if_req_ready", 64'(if_req_ready), 64'(e_if_rdy));
    chk("lsu_req_ready", 64'(lsu_req_ready), 64'(e_lsu_rdy));
    e_mvalid = m_busy && !m_issued;
    chk("mem_req_valid", 64'(mem_req_valid), 64'(e_mvalid));
    e_addr = m_own_if ? (m_addr & ~64'h7) : m_addr;
    if (e_mvalid) begin
      chk("mem_req_addr", mem_req_addr, e_addr);
      chk("mem_req_wen", 64'(mem_req_wen), 64'(m_wen));
      chk("mem_req_wdata", mem_req_wdata, m_wdata);
      chk("mem_req_wmask", 64'(mem_req_wmask), 64'(m_wmask));
      issue_cycles++; last_mem_addr = mem_req_addr;
    end
    e_ifr = m_resp_now && m_own_if && !m_drop;
    e_lr  = m_resp_now && !m_own_if;
    chk("if_resp_valid", 64'(if_resp_valid), 64'(e_ifr));
    chk("lsu_resp_valid", 64'(lsu_resp_valid), 64'(e_lr));
    if (e_ifr) chk("if_resp_inst", 64'(if_resp_inst), 64'(m_addr[2] ? m_rdata[63:32] : m_rdata[31:0]));
    if (e_lr)  chk("lsu_resp_rdata", lsu_resp_rdata, m_rdata);
    if (if_resp_valid === 1'b1) begin
      if_resp_cnt++; last_ifresp_cyc = cyc; last_inst = if_resp_inst;
    end
    if (lsu_resp_valid === 1'b1) begin
      lsu_resp_cnt++; last_lsu_rdata = lsu_resp_rdata;
    end

    if (rst_n) begin
      if (m_resp_now) begin
        m_busy = 0; m_issued = 0; m_resp_now = 0; m_drop = 0;
      end else if (!m_busy) begin
        if (e_if_rdy) begin
          m_own_if = 1; m_addr = if_req_addr; m_wen = 0; m_wdata = 0; m_wmask = 0;
          m_streak = 0; m_busy = 1; m_issued = 0; m_drop = 0;
          grant_log = {grant_log, "I"}; last_grant_cyc = cyc;
          if (auto_if) if_addr_q = if_addr_q + 64'd4; else if_pend = 0;
        end else if (e_lsu_rdy) begin
          m_own_if = 0; m_addr = lsu_req_addr; m_wen = lsu_req_wen; m_wdata = lsu_req_wdata;
          m_wmask = lsu_req_wmask; m_busy = 1; m_issued = 0; m_drop = 0;
          if (if_req_valid && m_streak < MAX) m_streak++;
          grant_log = {grant_log, "L"};
          if (auto_lsu) lsu_addr_q = lsu_addr_q + 64'd8; else lsu_pend = 0;
        end
        if (rnd && if_flush && if_pend) if_addr_q = 64'h8000_0000 + 64'($urandom_range(0, 1023) * 4);
      end else if (!m_issued) begin
        if (m_own_if && if_flush) m_drop = 1;
        if (mem_req_ready) begin
          m_issued = 1; mm_pending = 1; mm_addr = e_addr;
          mm_delay = (mm_dly_fixed >= 0) ? mm_dly_fixed : int'($urandom_range(0, 3));
        end
      end else begin
        if (m_own_if && if_flush) m_drop = 1;
        if (mem_resp_valid) begin
          m_rdata = mem_resp_rdata; m_resp_now = 1;
        end
      end
    end
    cyc++;
    @(posedge clk); #1;
    if (!rnd) if_flush = 0;
  endtask

  task automatic run_until_idle(input string tag, input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (!m_busy && !if_pend && !lsu_pend) begin ok = 1; break; end
      cycle(0);
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic run_until_issued(input string tag, input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (m_busy && m_issued) begin ok = 1; break; end
      cycle(0);
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    int ifc, lsc;
    rst_n = 0; if_flush = 0; if_req_valid = 0; lsu_req_valid = 0;
    if_pend = 0; lsu_pend = 0; auto_if = 0; auto_lsu = 0;
    if_addr_q = 0; lsu_addr_q = 0; lsu_wdata_q = 0; lsu_wen_q = 0; lsu_wmask_q = 0;
    mm_pending = 0; mm_ready_rand = 0; stray_en = 0; ovr_en = 0;
    mm_delay = 0; mm_dly_fixed = 0; mm_stall = 0; mm_addr = 0; ovr_data = 0;
    m_busy = 0; m_issued = 0; m_resp_now = 0; m_own_if = 1; m_drop = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0; m_wen = 0; m_wmask = 0; m_streak = 0;
    grant_log = ""; cyc = 0; last_grant_cyc = 0; last_ifresp_cyc = 0; issue_cycles = 0;
    if_resp_cnt = 0; lsu_resp_cnt = 0; last_mem_addr = 0; last_lsu_rdata = 0; last_inst = 0;
    #1;

    // Reset state, including requests raised while reset is held
    if_pend = 1; if_addr_q = 64'h8000_0040; lsu_pend = 1; lsu_addr_q = 64'h8000_1040;
    cycle(0); cycle(0);
    chk("rst_mem_addr", mem_req_addr, 64'd0);
    chk("rst_if_inst", 64'(if_resp_inst), 64'd0);
    chk("rst_lsu_rdata", lsu_resp_rdata, 64'd0);
    chk("rst_mem_wdata", mem_req_wdata, 64'd0);
    if_pend = 0; lsu_pend = 0;
    rst_n = 1;
    cycle(0);

    // Lone IF fetch: inst select, address alignment and 3-cycle latency
    ovr_en = 1; ovr_data = 64'h00100093_00000413;
    if_pend = 1; if_addr_q = 64'h8000_0004; ifc = if_resp_cnt;
    run_until_idle("t1_timeout", 20);
    chk("t1_count", 64'(if_resp_cnt - ifc), 64'd1);
    chk("t1_inst", 64'(last_inst), 64'h0010_0093);
    chk("t1_latency", 64'(last_ifresp_cyc - last_grant_cyc), 64'd3);
    chk("t1_mem_addr", last_mem_addr, 64'h8000_0000);
    ovr_en = 0;

    // Simultaneous IF + LSU load: LSU first, IF next
    grant_log = "";
    if_pend = 1; if_addr_q = 64'h8000_0100;
    lsu_pend = 1; lsu_addr_q = 64'h8000_1000; lsu_wen_q = 0; lsu_wdata_q = 0; lsu_wmask_q = 0;
    run_until_idle("t2_timeout", 30);
    chk_str("t2_order", grant_log, "LI");
    chk("t2_lsu_rdata", last_lsu_rdata, rd(64'h8000_1000));

    // Starvation guard
    grant_log = ""; auto_if = 1; auto_lsu = 1; if_pend = 1; lsu_pend = 1;
    for (int i = 0; i < 120 && grant_log.len() < 10; i++) cycle(0);
    auto_if = 0; auto_lsu = 0; if_pend = 0; lsu_pend = 0;
    run_until_idle("t3_drain", 20);
    chk_str("t3_order", grant_log.substr(0, 9), "LLLLILLLLI");

    // Flush during WAIT drops the fetch; next fetch is normal
    mm_dly_fixed = 2; ifc = if_resp_cnt;
    if_pend = 1; if_addr_q = 64'h8000_0008;
    run_until_issued("t4_issue", 20);
    if_flush = 1; cycle(0);
    run_until_idle("t4_idle", 20);
    chk("t4_dropped", 64'(if_resp_cnt - ifc), 64'd0);
    mm_dly_fixed = 0;
    if_pend = 1; if_addr_q = 64'h8000_0010;
    run_until_idle("t4_next", 20);
    chk("t4_next_count", 64'(if_resp_cnt - ifc), 64'd1);
    chk("t4_next_inst", 64'(last_inst), 64'(rd(64'h8000_0010) & 64'hFFFF_FFFF));

    // Store with memory back-pressure
    lsc = lsu_resp_cnt; issue_cycles = 0; mm_stall = 3;
    lsu_pend = 1; lsu_addr_q = 64'h8000_2000; lsu_wen_q = 1;
    lsu_wdata_q = 64'hDEAD_BEEF; lsu_wmask_q = 8'h0F;
    run_until_idle("t5_timeout", 30);
    for (int i = 0; i < 3; i++) cycle(0);
    chk("t5_issue_cycles", 64'(issue_cycles), 64'd4);
    chk("t5_pulses", 64'(lsu_resp_cnt - lsc), 64'd1);

    // Reset during WAIT, followed by a late response
    mm_dly_fixed = 3; ifc = if_resp_cnt; lsc = lsu_resp_cnt;
    if_pend = 1; if_addr_q = 64'h8000_0020;
    run_until_issued("t6_issue", 20);
    cycle(0);
    rst_n = 0; cycle(0); rst_n = 1;
    mm_dly_fixed = 0;
    for (int i = 0; i < 6; i++) cycle(0);
    chk("t6_no_if_resp", 64'(if_resp_cnt - ifc), 64'd0);
    chk("t6_no_lsu_resp", 64'(lsu_resp_cnt - lsc), 64'd0);
    lsu_pend = 1; lsu_addr_q = 64'h8000_3000; lsu_wen_q = 0;
    run_until_idle("t6_next", 20);
    chk("t6_next_count", 64'(lsu_resp_cnt - lsc), 64'd1);
    chk("t6_next_rdata", last_lsu_rdata, rd(64'h8000_3000));

    // Randomized traffic: back-pressure, variable latency, stray responses, flushes
    mm_ready_rand = 1; mm_dly_fixed = -1; stray_en = 1;
    ifc = if_resp_cnt; lsc = lsu_resp_cnt;
    for (int i = 0; i < 3000; i++) cycle(1);
    if_flush = 0; stray_en = 0; mm_ready_rand = 0; mm_dly_fixed = 0;
    if_pend = 0; lsu_pend = 0;
    run_until_idle("rand_drain", 30);
    chk("rand_if_activity", 64'(if_resp_cnt > ifc), 64'd1);
    chk("rand_lsu_activity", 64'(lsu_resp_cnt > lsc), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
